// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared types and constants for the video write buffer
package vid_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DROP   = 2'd3
  } vid_state_t;

  localparam int H_ACT_DEF   = 1024;
  localparam int V_ACT_DEF   = 768;
  localparam int FIFO_AW_DEF = 8;
  localparam int PIX_W       = 24;

  // One slot is sacrificed so usedw fits in FIFO_AW bits.
  localparam int FIFO_CAP    = (1 << FIFO_AW_DEF) - 1;

endpackage

// File: rtl/vid_wr_fifo.sv
// rtl/vid_wr_fifo.sv - single-clock normal-mode pixel FIFO with occupancy count
module vid_wr_fifo
  import vid_pkg::*;
#(
  parameter int AW = FIFO_AW_DEF
) (
  input  logic             afi_clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_dat,
  input  logic             rd_req,
  output logic [PIX_W-1:0] rd_dat,
  output logic [AW-1:0]    usedw,
  output logic             full
);

  logic [PIX_W-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, usedw_q;
  logic [PIX_W-1:0] rd_dat_q;
  logic             wr_ok, rd_ok;

  assign full   = (usedw_q == {AW{1'b1}});
  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_req && (usedw_q != '0);
  assign usedw  = usedw_q;
  assign rd_dat = rd_dat_q;

  // Storage array; contents are don't-care after reset since pointers clear.
  always_ff @(posedge afi_clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_dat;
  end

  // Pointers, occupancy and registered read data; empty reads leave data held.
  always_ff @(posedge afi_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      rd_dat_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_dat_q <= mem[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   usedw_q <= usedw_q + 1'b1;
        2'b01:   usedw_q <= usedw_q - 1'b1;
        default: usedw_q <= usedw_q;
      endcase
    end
  end

endmodule

// File: rtl/vid_wr_buf.sv
// rtl/vid_wr_buf.sv - frame-aligned pixel write buffer (option: VID_WR_BUF_ERRCNT_EN)
module vid_wr_buf
  import vid_pkg::*;
#(
  parameter int H_ACT   = H_ACT_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic               afi_clk,
  input  logic               rstn,
  input  logic               pix_vs,
  input  logic               pix_de,
  input  logic [PIX_W-1:0]   pix_dat,
  input  logic               buf_wr_fifo_req,
  output logic [PIX_W-1:0]   buf_wr_dat,
  output logic [FIFO_AW-1:0] buf_wr_usedw,
  output logic               frame_start,
  output logic               frame_done,
  output logic               ovf,
  output logic [15:0]        ovf_cnt
);

  localparam logic [10:0] H_LAST = 11'(H_ACT - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACT - 1);

  vid_state_t  state_q;
  logic        vs_q;
  logic [10:0] pix_cnt_q;
  logic [9:0]  line_cnt_q;
  logic        frame_start_q, frame_done_q, ovf_q;
  logic        vs_rise, vs_fall, fifo_full, wr_en, last_pix, first_pix, ovf_set;

  assign vs_rise   = pix_vs && !vs_q;
  assign vs_fall   = !pix_vs && vs_q;
  assign wr_en     = (state_q == ST_ACTIVE) && pix_de && !fifo_full;
  assign last_pix  = (pix_cnt_q == H_LAST) && (line_cnt_q == V_LAST);
  assign first_pix = (pix_cnt_q == '0) && (line_cnt_q == '0);
  // A vs rise that lands on the last-pixel write completes the frame normally.
  assign ovf_set   = (state_q == ST_ACTIVE) && !(wr_en && last_pix) &&
                     ((pix_de && fifo_full) || vs_rise);

  vid_wr_fifo #(.AW(FIFO_AW)) u_fifo (
    .afi_clk (afi_clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_dat  (pix_dat),
    .rd_req  (buf_wr_fifo_req),
    .rd_dat  (buf_wr_dat),
    .usedw   (buf_wr_usedw),
    .full    (fifo_full)
  );

  // Frame FSM with pixel/line counters and registered status pulses.
  always_ff @(posedge afi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_SYNC;
      vs_q          <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      vs_q          <= pix_vs;
      frame_start_q <= wr_en && first_pix;
      frame_done_q  <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      case (state_q)
        ST_SYNC: if (vs_rise) state_q <= ST_ARM;
        ST_ARM: begin
          if (vs_fall) begin
            state_q    <= ST_ACTIVE;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (wr_en && !last_pix) begin
            if (pix_cnt_q == H_LAST) begin
              pix_cnt_q  <= '0;
              line_cnt_q <= line_cnt_q + 10'd1;
            end else begin
              pix_cnt_q <= pix_cnt_q + 11'd1;
            end
          end
          if (wr_en && last_pix) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_ARM;
          end else if (pix_de && fifo_full) begin
            state_q <= ST_DROP;
          end else if (vs_rise) begin
            state_q <= ST_ARM;
          end
        end
        ST_DROP: if (vs_rise) state_q <= ST_ARM;
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign ovf         = ovf_q;

`ifdef VID_WR_BUF_ERRCNT_EN
  logic [15:0] ovf_cnt_q;

  // Count frames that overflowed: ovf can only go 0->1 once per frame.
  always_ff @(posedge afi_clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt_q <= '0;
    end else if (ovf_set && !ovf_q && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vid_wr_buf.sv
// tb/tb_vid_wr_buf.sv - directed self-checking bench for vid_wr_buf
module tb_vid_wr_buf;
  import vid_pkg::*;

`ifdef VID_WR_BUF_ERRCNT_EN
  localparam logic [15:0] EXP_CNT3 = 16'd3;
`else
  localparam logic [15:0] EXP_CNT3 = 16'd0;
`endif

  logic afi_clk = 1'b0;
  always #5 afi_clk = ~afi_clk;

  logic rstn;

  logic        vs_s, de_s, req_s;
  logic [23:0] dat_s, rd_s;
  logic [7:0]  usedw_s;
  logic        fs_s, fd_s, ovf_s;
  logic [15:0] ocnt_s;

  logic        vs_l, de_l, req_l;
  logic [23:0] dat_l, rd_l;
  logic [7:0]  usedw_l;
  logic        fs_l, fd_l, ovf_l;
  logic [15:0] ocnt_l;

  int n_total = 0;
  int n_pass  = 0;

  vid_wr_buf #(.H_ACT(4), .V_ACT(2), .FIFO_AW(8)) dut_s (
    .afi_clk(afi_clk), .rstn(rstn), .pix_vs(vs_s), .pix_de(de_s), .pix_dat(dat_s),
    .buf_wr_fifo_req(req_s), .buf_wr_dat(rd_s), .buf_wr_usedw(usedw_s),
    .frame_start(fs_s), .frame_done(fd_s), .ovf(ovf_s), .ovf_cnt(ocnt_s)
  );

  vid_wr_buf #(.H_ACT(1024), .V_ACT(768), .FIFO_AW(8)) dut_l (
    .afi_clk(afi_clk), .rstn(rstn), .pix_vs(vs_l), .pix_de(de_l), .pix_dat(dat_l),
    .buf_wr_fifo_req(req_l), .buf_wr_dat(rd_l), .buf_wr_usedw(usedw_l),
    .frame_start(fs_l), .frame_done(fd_l), .ovf(ovf_l), .ovf_cnt(ocnt_l)
  );

  task automatic step();
    @(posedge afi_clk);
    #1;
  endtask

  task automatic vs_seq_s();
    vs_s = 1'b1; step();
    vs_s = 1'b0; step();
  endtask

  task automatic vs_seq_l();
    vs_l = 1'b1; step();
    vs_l = 1'b0; step();
  endtask

  task automatic push_s(input logic [23:0] d);
    de_s = 1'b1; dat_s = d; step(); de_s = 1'b0;
  endtask

  task automatic push_l(input logic [23:0] d);
    de_l = 1'b1; dat_l = d; step(); de_l = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    vs_s = 0; de_s = 0; dat_s = 0; req_s = 0;
    vs_l = 0; de_l = 0; dat_l = 0; req_l = 0;
    step(); step();
    n_total++; if (usedw_s !== 8'd0) $display("FAIL reset_usedw: got %0d want 0", usedw_s); else n_pass++;
    n_total++; if (rd_s !== 24'd0) $display("FAIL reset_dat: got %h want 0", rd_s); else n_pass++;
    n_total++; if (fs_s !== 1'b0) $display("FAIL reset_fs: got %b want 0", fs_s); else n_pass++;
    n_total++; if (fd_s !== 1'b0) $display("FAIL reset_fd: got %b want 0", fd_s); else n_pass++;
    n_total++; if (ovf_s !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_s); else n_pass++;
    n_total++; if (ocnt_s !== 16'd0) $display("FAIL reset_ovf_cnt: got %0d want 0", ocnt_s); else n_pass++;
    n_total++; if (dut_l.state_q !== ST_SYNC) $display("FAIL reset_state: got %0d want %0d", dut_l.state_q, ST_SYNC); else n_pass++;
    rstn = 1'b1;
    step();
    push_s(24'h777777);
    n_total++; if (usedw_s !== 8'd0) $display("FAIL sync_no_write: got %0d want 0", usedw_s); else n_pass++;
  endtask

  task automatic test_frame_4x2();
    vs_seq_s();
    for (int i = 1; i <= 8; i++) begin
      push_s(24'(i));
      n_total++; if (usedw_s !== 8'(i)) $display("FAIL frame_usedw[%0d]: got %0d want %0d", i, usedw_s, i); else n_pass++;
      n_total++; if (fs_s !== (i == 1)) $display("FAIL frame_start[%0d]: got %b want %b", i, fs_s, (i == 1)); else n_pass++;
      n_total++; if (fd_s !== (i == 8)) $display("FAIL frame_done[%0d]: got %b want %b", i, fd_s, (i == 8)); else n_pass++;
    end
    push_s(24'hABCDEF);
    n_total++; if (usedw_s !== 8'd8) $display("FAIL arm_discard: got %0d want 8", usedw_s); else n_pass++;
    n_total++; if (fd_s !== 1'b0) $display("FAIL fd_one_cycle: got %b want 0", fd_s); else n_pass++;
  endtask

  task automatic test_read();
    for (int i = 1; i <= 8; i++) begin
      req_s = 1'b1; step(); req_s = 1'b0;
      n_total++; if (rd_s !== 24'(i)) $display("FAIL read_dat[%0d]: got %h want %h", i, rd_s, 24'(i)); else n_pass++;
      n_total++; if (usedw_s !== 8'(8 - i)) $display("FAIL read_usedw[%0d]: got %0d want %0d", i, usedw_s, 8 - i); else n_pass++;
    end
    req_s = 1'b1; step(); req_s = 1'b0;
    n_total++; if (rd_s !== 24'd8) $display("FAIL empty_read_hold: got %h want 000008", rd_s); else n_pass++;
    n_total++; if (usedw_s !== 8'd0) $display("FAIL empty_read_usedw: got %0d want 0", usedw_s); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_d;
    logic [23:0] drain [4];
    drain[0] = 24'h23; drain[1] = 24'h30; drain[2] = 24'h31; drain[3] = 24'h32;
    vs_seq_s();
    push_s(24'h10);
    n_total++; if (fs_s !== 1'b1) $display("FAIL b2b_fs: got %b want 1", fs_s); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      de_s = 1'b1; dat_s = 24'h20 + 24'(i); req_s = 1'b1;
      step();
      de_s = 1'b0; req_s = 1'b0;
      exp_d = (i == 0) ? 24'h10 : 24'h20 + 24'(i - 1);
      n_total++; if (usedw_s !== 8'd1) $display("FAIL b2b_usedw[%0d]: got %0d want 1", i, usedw_s); else n_pass++;
      n_total++; if (rd_s !== exp_d) $display("FAIL b2b_dat[%0d]: got %h want %h", i, rd_s, exp_d); else n_pass++;
    end
    push_s(24'h30); push_s(24'h31); push_s(24'h32);
    n_total++; if (fd_s !== 1'b1) $display("FAIL b2b_fd: got %b want 1", fd_s); else n_pass++;
    n_total++; if (usedw_s !== 8'd4) $display("FAIL b2b_usedw_end: got %0d want 4", usedw_s); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      req_s = 1'b1; step(); req_s = 1'b0;
      n_total++; if (rd_s !== drain[i]) $display("FAIL b2b_drain[%0d]: got %h want %h", i, rd_s, drain[i]); else n_pass++;
    end
  endtask

  task automatic test_short_frame();
    vs_seq_s();
    push_s(24'h1); push_s(24'h2); push_s(24'h3);
    vs_s = 1'b1; step();
    n_total++; if (ovf_s !== 1'b1) $display("FAIL short_ovf: got %b want 1", ovf_s); else n_pass++;
    n_total++; if (fd_s !== 1'b0) $display("FAIL short_no_fd: got %b want 0", fd_s); else n_pass++;
    vs_s = 1'b0; step();
    n_total++; if (ovf_s !== 1'b0) $display("FAIL short_ovf_clear: got %b want 0", ovf_s); else n_pass++;
    for (int i = 0; i < 8; i++) push_s(24'h40 + 24'(i));
    n_total++; if (fd_s !== 1'b1) $display("FAIL short_next_fd: got %b want 1", fd_s); else n_pass++;
    n_total++; if (usedw_s !== 8'd11) $display("FAIL short_usedw: got %0d want 11", usedw_s); else n_pass++;
    req_s = 1'b1; step();
    n_total++; if (rd_s !== 24'h1) $display("FAIL short_first_rd: got %h want 000001", rd_s); else n_pass++;
    for (int i = 0; i < 10; i++) step();
    req_s = 1'b0;
    n_total++; if (rd_s !== 24'h47) $display("FAIL short_last_rd: got %h want 000047", rd_s); else n_pass++;
    n_total++; if (usedw_s !== 8'd0) $display("FAIL short_drained: got %0d want 0", usedw_s); else n_pass++;
  endtask

  task automatic test_overflow();
    vs_seq_l();
    for (int i = 0; i < 255; i++) push_l(24'(i + 1));
    n_total++; if (usedw_l !== 8'd255) $display("FAIL ovf_full_usedw: got %0d want 255", usedw_l); else n_pass++;
    n_total++; if (ovf_l !== 1'b0) $display("FAIL ovf_not_yet: got %b want 0", ovf_l); else n_pass++;
    push_l(24'h999);
    n_total++; if (ovf_l !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf_l); else n_pass++;
    n_total++; if (usedw_l !== 8'd255) $display("FAIL ovf_usedw: got %0d want 255", usedw_l); else n_pass++;
    n_total++; if (dut_l.state_q !== ST_DROP) $display("FAIL ovf_state_drop: got %0d want %0d", dut_l.state_q, ST_DROP); else n_pass++;
    push_l(24'h998);
    n_total++; if (usedw_l !== 8'd255) $display("FAIL drop_discard: got %0d want 255", usedw_l); else n_pass++;
    vs_l = 1'b1; step();
    n_total++; if (dut_l.state_q !== ST_ARM) $display("FAIL drop_to_arm: got %0d want %0d", dut_l.state_q, ST_ARM); else n_pass++;
    n_total++; if (ovf_l !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf_l); else n_pass++;
    vs_l = 1'b0; step();
    n_total++; if (ovf_l !== 1'b0) $display("FAIL ovf_frame_clear: got %b want 0", ovf_l); else n_pass++;
    n_total++; if (dut_l.state_q !== ST_ACTIVE) $display("FAIL arm_to_active: got %0d want %0d", dut_l.state_q, ST_ACTIVE); else n_pass++;
    req_l = 1'b1; step(); req_l = 1'b0;
    n_total++; if (rd_l !== 24'h1) $display("FAIL ovf_first_rd: got %h want 000001", rd_l); else n_pass++;
  endtask

  task automatic test_reset_mid();
    req_l = 1'b1;
    for (int i = 0; i < 214; i++) step();
    req_l = 1'b0;
    n_total++; if (usedw_l !== 8'd40) $display("FAIL pre_reset_usedw: got %0d want 40", usedw_l); else n_pass++;
    @(posedge afi_clk); #2;
    rstn = 1'b0;
    #1;
    n_total++; if (usedw_l !== 8'd0) $display("FAIL async_reset_usedw: got %0d want 0", usedw_l); else n_pass++;
    n_total++; if (rd_l !== 24'd0) $display("FAIL async_reset_dat: got %h want 0", rd_l); else n_pass++;
    step();
    rstn = 1'b1;
    push_l(24'h51); push_l(24'h52); push_l(24'h53);
    n_total++; if (usedw_l !== 8'd0) $display("FAIL post_reset_discard: got %0d want 0", usedw_l); else n_pass++;
    vs_seq_l();
    push_l(24'h55);
    n_total++; if (usedw_l !== 8'd1) $display("FAIL post_reset_write: got %0d want 1", usedw_l); else n_pass++;
    n_total++; if (fs_l !== 1'b1) $display("FAIL post_reset_fs: got %b want 1", fs_l); else n_pass++;
  endtask

  task automatic test_errcnt();
    vs_seq_s();
    for (int k = 0; k < 3; k++) begin
      push_s(24'(k));
      vs_seq_s();
    end
    n_total++; if (ocnt_s !== EXP_CNT3) $display("FAIL ovf_cnt: got %0d want %0d", ocnt_s, EXP_CNT3); else n_pass++;
    n_total++; if (ovf_s !== 1'b0) $display("FAIL errcnt_ovf_clear: got %b want 0", ovf_s); else n_pass++;
    n_total++; if (usedw_s !== 8'd3) $display("FAIL errcnt_usedw: got %0d want 3", usedw_s); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_4x2();
    test_read();
    test_back_to_back();
    test_short_frame();
    test_overflow();
    test_reset_mid();
    test_errcnt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
